lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised Fibonacci LFSR generator for the Massey-Rueppel PRNG datapath, superseding the fixed 7-bit register. Width, feedback taps, shifts-per-word and reset seed are parameters. A small control FSM adds runtime seed load, start/stop, a valid/ready output stream and all-zero lock-up detection. It feeds the combiner/multiplier stage, which consumes one state word per handshake.

## Interface
- WIDTH, 7, LFSR length in bits (≥2)
- TAPS, 7'b1000001, feedback mask; fb = XOR of (state & TAPS)
- STEP, 1, shifts applied per accepted word (1..WIDTH)
- DEFAULT_SEED, 7'b0000001, state loaded at reset (must be nonzero)
- CNT_W, 16, width of the period counter
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_load  in  1  load i_seed into state (one-cycle strobe)
- i_seed  in  WIDTH  seed value sampled when i_load=1
- i_start  in  1  IDLE→RUN request
- i_stop  in  1  RUN→IDLE request
- i_ready  in  1  downstream accepts o_state
- o_valid  out  1  o_state is a valid word
- o_state  out  WIDTH  current LFSR contents
- o_bit  out  1  o_state[0], serial keystream bit
- o_lockup  out  1  state is all-zero (LOCK state)
- o_wrap  out  1  one-cycle pulse when sequence returns to the loaded seed
- o_period  out  CNT_W  words accepted between load and the last wrap

## Operation
- Single shift: next = {fb, state[WIDTH-1:1]}, fb = ^(state & TAPS). One advance = STEP consecutive single shifts, computed combinationally.
- FSM states:
  - IDLE: o_valid=0; state held.
  - RUN: o_valid=1; advance on o_valid & i_ready.
  - LOCK: o_valid=0, o_lockup=1; exited only by i_load with a nonzero seed, or by reset.
- Transitions: IDLE --i_start--> RUN; RUN --i_stop--> IDLE; any state --i_load, seed==0--> LOCK; LOCK/IDLE --i_load, seed≠0--> same state as before the load (LOCK→IDLE); RUN --i_load, seed≠0--> RUN.
- Priority: i_rst > i_load > i_stop > i_start > advance. If i_load coincides with a handshake, the load wins and the accepted word is not advanced past.
- i_start and i_stop asserted together: i_stop wins.
- o_state holds stable while o_valid=1 and i_ready=0.
- Reset values: state=DEFAULT_SEED, FSM=IDLE, o_valid=0, o_lockup=0, o_wrap=0, o_period=0, o_bit=DEFAULT_SEED[0]. The loaded-seed capture register resets to DEFAULT_SEED and the counter to 0.

## Timing
- Load at cycle t: o_state=i_seed at t+1. Counter cleared at t+1.
- Handshake at cycle t: o_state shows the advanced value at t+1. Throughput is one word per cycle.
- i_start at t: o_valid=1 at t+1. i_stop at t: o_valid=0 at t+1.
- Zero seed load at t: o_lockup=1 and o_valid=0 at t+1.
- Outputs are registered; no combinational path from i_ready to o_valid or o_state.

## Configuration
- LFSR_GEN_WRAP_DET_EN defined:
  - Counter increments on each handshake and saturates at 2^CNT_W−1.
  - When the advanced state equals the captured seed, o_wrap pulses for 1 cycle, aligned with the wrapped o_state.
  - At the same time, o_period is set to count+1 and the counter restarts at 0.
- Not defined: counter and seed capture are absent; o_wrap=0 and o_period=0 constantly.

## Structure
- lfsr_gen_pkg holds the FSM state enum (ST_IDLE, ST_RUN, ST_LOCK) and default parameter constants.
- Sub-module lfsr_gen_step is the purely combinational STEP-shift next-state function, parametrised by WIDTH/TAPS/STEP. It is reused by the combiner model.

## Test plan
- Defaults, reset, i_start, i_ready=1 -> o_state sequence 0x01, 0x40, 0x60, 0x70, 0x78 on consecutive cycles.
- Defaults with LFSR_GEN_WRAP_DET_EN, load 0x01, run continuously -> o_wrap pulses every 127 handshakes; o_period=127.
- i_ready held 0 for 5 cycles in RUN -> o_state stable at the same value, o_valid=1 throughout.
- Load 0x00 while in RUN -> next cycle o_lockup=1, o_valid=0. Then load 0x05 -> o_lockup=0, FSM in IDLE, o_state=0x05.
- STEP=7, seed 0x01 -> first advance yields the value that STEP=1 reaches after 7 handshakes.
- i_load (seed 0x11) in the same cycle as a handshake in RUN -> o_state=0x11 next cycle, o_valid=1. Separately, i_rst mid-run -> o_state=0x01, o_valid=0 next cycle.

Source files
------------

// File: rtl/lfsr_gen_pkg.sv
// Shared types and default constants for the lfsr_gen PRNG block.
// Holds the control FSM encoding used by the top and its users.
package lfsr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } lfsr_state_e;

    localparam int         LFSR_WIDTH_DEF = 7;
    localparam logic [6:0] LFSR_TAPS_DEF  = 7'b1000001;
    localparam int         LFSR_STEP_DEF  = 1;
    localparam logic [6:0] LFSR_SEED_DEF  = 7'b0000001;
    localparam int         LFSR_CNT_W_DEF = 16;

endpackage

// File: rtl/lfsr_gen_if.sv
// Control and output-stream bundle of the lfsr_gen block.
// The generator sits on the slave side; the stimulus/consumer on master.
interface lfsr_gen_if
    import lfsr_gen_pkg::*;
#(
    parameter int WIDTH = LFSR_WIDTH_DEF,
    parameter int CNT_W = LFSR_CNT_W_DEF
);
    logic             i_load;
    logic [WIDTH-1:0] i_seed;
    logic             i_start;
    logic             i_stop;
    logic             i_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_state;
    logic             o_bit;
    logic             o_lockup;
    logic             o_wrap;
    logic [CNT_W-1:0] o_period;

    modport master (
        output i_load, i_seed, i_start, i_stop, i_ready,
        input  o_valid, o_state, o_bit, o_lockup, o_wrap, o_period
    );

    modport slave (
        input  i_load, i_seed, i_start, i_stop, i_ready,
        output o_valid, o_state, o_bit, o_lockup, o_wrap, o_period
    );
endinterface

// File: rtl/lfsr_gen_step.sv
// Combinational STEP-fold Fibonacci LFSR next-state function.
// Shared with the combiner model, so it carries no state of its own.
module lfsr_gen_step
    import lfsr_gen_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEF,
    parameter int               STEP  = LFSR_STEP_DEF
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next
);
    always_comb begin
        logic [WIDTH-1:0] v;
        v = i_state;
        for (int k = 0; k < STEP; k++) begin
            v = {^(v & TAPS), v[WIDTH-1:1]};
        end
        o_next = v;
    end
endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with load/start/stop control and valid/ready out.
// Define LFSR_GEN_WRAP_DET_EN to build the seed-wrap detector and period counter.
module lfsr_gen
    import lfsr_gen_pkg::*;
#(
    parameter int               WIDTH        = LFSR_WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS         = LFSR_TAPS_DEF,
    parameter int               STEP         = LFSR_STEP_DEF,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_SEED_DEF,
    parameter int               CNT_W        = LFSR_CNT_W_DEF
) (
    input logic      i_clk,
    input logic      i_rst,
    lfsr_gen_if.slave bus
);
    lfsr_state_e      r_fsm;
    logic [WIDTH-1:0] r_state;
    logic             r_valid;
    logic             r_lockup;
    logic [WIDTH-1:0] w_next;
    logic             w_seed_zero;
    logic             w_adv;

    lfsr_gen_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEP  (STEP)
    ) u_step (
        .i_state (r_state),
        .o_next  (w_next)
    );

    assign w_seed_zero = (bus.i_seed == '0);
    // Load and stop both outrank the handshake, so neither may advance.
    assign w_adv = r_valid & bus.i_ready & ~bus.i_stop & ~bus.i_load;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fsm    <= ST_IDLE;
            r_state  <= DEFAULT_SEED;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end else if (bus.i_load) begin
            r_state <= bus.i_seed;
            if (w_seed_zero) begin
                r_fsm    <= ST_LOCK;
                r_valid  <= 1'b0;
                r_lockup <= 1'b1;
            end else begin
                r_lockup <= 1'b0;
                if (r_fsm == ST_LOCK) begin
                    r_fsm   <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            end
        end else begin
            unique case (r_fsm)
                ST_IDLE: begin
                    if (bus.i_start && !bus.i_stop) begin
                        r_fsm   <= ST_RUN;
                        r_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.i_stop) begin
                        r_fsm   <= ST_IDLE;
                        r_valid <= 1'b0;
                    end else if (w_adv) begin
                        r_state <= w_next;
                    end
                end
                ST_LOCK: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_fsm   <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_valid  = r_valid;
    assign bus.o_state  = r_state;
    assign bus.o_bit    = r_state[0];
    assign bus.o_lockup = r_lockup;

`ifdef LFSR_GEN_WRAP_DET_EN
    logic [WIDTH-1:0] r_seed;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_wrap;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seed   <= DEFAULT_SEED;
            r_cnt    <= '0;
            r_period <= '0;
            r_wrap   <= 1'b0;
        end else if (bus.i_load) begin
            r_seed <= bus.i_seed;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_adv) begin
            if (w_next == r_seed) begin
                r_wrap   <= 1'b1;
                r_period <= w_cnt_inc;
                r_cnt    <= '0;
            end else begin
                r_wrap <= 1'b0;
                r_cnt  <= w_cnt_inc;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign bus.o_wrap   = r_wrap;
    assign bus.o_period = r_period;
`else
    assign bus.o_wrap   = 1'b0;
    assign bus.o_period = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed scenarios plus randomized
// control traffic compared against a behavioural generator model.
module tb_lfsr_gen;
    localparam int         W     = 7;
    localparam int         CW    = 16;
    localparam logic [6:0] TAPS  = 7'b1000001;
    localparam logic [6:0] SEED  = 7'h01;
    localparam int         CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    lfsr_gen_if #(.WIDTH(W), .CNT_W(CW)) bus7 ();

    lfsr_gen #(.WIDTH(W), .TAPS(TAPS), .STEP(1), .DEFAULT_SEED(SEED), .CNT_W(CW))
        u_dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    lfsr_gen #(.WIDTH(W), .TAPS(TAPS), .STEP(7), .DEFAULT_SEED(SEED), .CNT_W(CW))
        u_dut7 (.i_clk(clk), .i_rst(rst), .bus(bus7));

    int n_checks = 0;
    int n_errors = 0;

    typedef enum {M_IDLE, M_RUN, M_LOCK} mode_t;
    mode_t      m_mode;
    logic [6:0] m_st, m_seed;
    int         m_cnt, m_per;
    bit         m_wrap;

    // n single shifts: new top bit is the parity of the tapped bits
    function automatic logic [6:0] adv(input logic [6:0] s, input int n);
        int v, fb;
        v = int'(s);
        for (int k = 0; k < n; k++) begin
            fb = $countones(7'(v) & TAPS) % 2;
            v  = v / 2 + fb * 64;
        end
        return 7'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_mode = M_IDLE; m_st = SEED; m_seed = SEED;
            m_cnt = 0; m_per = 0; m_wrap = 0;
        end else if (bus.i_load) begin
            m_st = bus.i_seed; m_seed = bus.i_seed; m_cnt = 0; m_wrap = 0;
            if (bus.i_seed == 0) m_mode = M_LOCK;
            else if (m_mode == M_LOCK) m_mode = M_IDLE;
        end else begin
            m_wrap = 0;
            if (m_mode == M_RUN && bus.i_stop) m_mode = M_IDLE;
            else if (m_mode == M_IDLE && bus.i_start && !bus.i_stop) m_mode = M_RUN;
            else if (m_mode == M_RUN && bus.i_ready) begin
                m_st = adv(m_st, 1);
                if (m_st == m_seed) begin
                    m_wrap = 1; m_per = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1; m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_load = 0; bus.i_seed = '0; bus.i_start = 0; bus.i_stop = 0; bus.i_ready = 0;
        bus7.i_load = 0; bus7.i_seed = '0; bus7.i_start = 0; bus7.i_stop = 0; bus7.i_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.o_state !== SEED) begin n_errors++; $display("FAIL reset_state got %h exp %h", bus.o_state, SEED); end
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_lockup !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags valid=%b lockup=%b exp 0/0", bus.o_valid, bus.o_lockup);
        end
        n_checks++;
        if (bus.o_bit !== SEED[0] || bus.o_wrap !== 1'b0 || bus.o_period !== '0) begin
            n_errors++; $display("FAIL reset_misc bit=%b wrap=%b period=%0d exp 1/0/0", bus.o_bit, bus.o_wrap, bus.o_period);
        end
    endtask

    task automatic test_sequence();
        logic [6:0] exp_tab [5] = '{7'h01, 7'h40, 7'h60, 7'h70, 7'h78};
        do_reset();
        bus.i_start = 1; bus.i_ready = 1;
        tick();
        bus.i_start = 0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.o_state !== exp_tab[i] || bus.o_valid !== 1'b1 || m_st !== exp_tab[i]) begin
                n_errors++;
                $display("FAIL seq[%0d] got %h v=%b exp %h v=1 (model %h)", i, bus.o_state, bus.o_valid, exp_tab[i], m_st);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [6:0] held;
        bus.i_ready = 0;
        held = m_st;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.o_state !== held || bus.o_valid !== 1'b1) begin
                n_errors++; $display("FAIL stall[%0d] got %h v=%b exp %h v=1", i, bus.o_state, bus.o_valid, held);
            end
        end
        bus.i_ready = 1; tick();
        n_checks++;
        if (bus.o_state !== adv(held, 1)) begin
            n_errors++; $display("FAIL stall_release got %h exp %h", bus.o_state, adv(held, 1));
        end
    endtask

    task automatic test_lockup();
        bus.i_ready = 1;
        bus.i_load = 1; bus.i_seed = 7'h00; tick();
        bus.i_load = 0;
        n_checks++;
        if (bus.o_lockup !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_state !== 7'h00) begin
            n_errors++; $display("FAIL lock_enter lk=%b v=%b st=%h exp 1/0/00", bus.o_lockup, bus.o_valid, bus.o_state);
        end
        bus.i_start = 1; tick(); bus.i_start = 0;
        n_checks++;
        if (bus.o_lockup !== 1'b1 || bus.o_valid !== 1'b0) begin
            n_errors++; $display("FAIL lock_hold lk=%b v=%b exp 1/0", bus.o_lockup, bus.o_valid);
        end
        bus.i_load = 1; bus.i_seed = 7'h05; tick(); bus.i_load = 0;
        n_checks++;
        if (bus.o_lockup !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_state !== 7'h05) begin
            n_errors++; $display("FAIL lock_exit lk=%b v=%b st=%h exp 0/0/05", bus.o_lockup, bus.o_valid, bus.o_state);
        end
        bus.i_start = 1; tick(); bus.i_start = 0;
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_state !== 7'h05) begin
            n_errors++; $display("FAIL lock_idle_start v=%b st=%h exp 1/05", bus.o_valid, bus.o_state);
        end
    endtask

    task automatic test_load_handshake();
        bus.i_ready = 1;
        bus.i_load = 1; bus.i_seed = 7'h11; tick(); bus.i_load = 0;
        n_checks++;
        if (bus.o_state !== 7'h11 || bus.o_valid !== 1'b1) begin
            n_errors++; $display("FAIL load_hs st=%h v=%b exp 11/1", bus.o_state, bus.o_valid);
        end
        bus.i_stop = 1; bus.i_start = 1; tick(); bus.i_stop = 0; bus.i_start = 0;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_state !== 7'h11) begin
            n_errors++; $display("FAIL stop_wins v=%b st=%h exp 0/11", bus.o_valid, bus.o_state);
        end
        bus.i_start = 1; tick(); bus.i_start = 0; tick(); tick();
        rst = 1; tick(); rst = 0;
        n_checks++;
        if (bus.o_state !== SEED || bus.o_valid !== 1'b0) begin
            n_errors++; $display("FAIL rst_mid st=%h v=%b exp 01/0", bus.o_state, bus.o_valid);
        end
    endtask

    task automatic test_step7();
        do_reset();
        bus7.i_start = 1; bus7.i_ready = 1; tick(); bus7.i_start = 0;
        tick();
        n_checks++;
        if (bus7.o_state !== adv(SEED, 7) || bus7.o_state !== 7'h7F) begin
            n_errors++; $display("FAIL step7 got %h exp %h", bus7.o_state, adv(SEED, 7));
        end
        tick();
        n_checks++;
        if (bus7.o_state !== adv(SEED, 14)) begin
            n_errors++; $display("FAIL step7_2nd got %h exp %h", bus7.o_state, adv(SEED, 14));
        end
        bus7.i_ready = 0;
    endtask

    task automatic test_wrap();
        int pulses = 0, last = -1;
        do_reset();
        bus.i_load = 1; bus.i_seed = 7'h01; tick(); bus.i_load = 0;
        bus.i_start = 1; bus.i_ready = 1; tick(); bus.i_start = 0;
        for (int hs = 1; hs <= 260; hs++) begin
            tick();
            if (bus.o_wrap === 1'b1) begin
                pulses++;
`ifdef LFSR_GEN_WRAP_DET_EN
                n_checks++;
                if (bus.o_state !== 7'h01 || bus.o_period !== 16'd127 || (last >= 0 && hs - last != 127)) begin
                    n_errors++; $display("FAIL wrap_pulse hs=%0d st=%h per=%0d exp 01/127", hs, bus.o_state, bus.o_period);
                end
`endif
                last = hs;
            end
        end
        n_checks++;
`ifdef LFSR_GEN_WRAP_DET_EN
        if (pulses != 2 || bus.o_period !== 16'd127) begin
            n_errors++; $display("FAIL wrap_count got %0d per=%0d exp 2/127", pulses, bus.o_period);
        end
`else
        if (pulses != 0 || bus.o_period !== '0) begin
            n_errors++; $display("FAIL wrap_absent pulses=%0d per=%0d exp 0/0", pulses, bus.o_period);
        end
`endif
    endtask

    task automatic test_random();
        bit  exp_wrap;
        int  exp_per;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.i_ready = ($urandom % 4) != 0;
            bus.i_start = ($urandom % 8) == 0;
            bus.i_stop  = ($urandom % 16) == 0;
            bus.i_load  = ($urandom % 40) == 0;
            bus.i_seed  = (($urandom % 6) == 0) ? 7'h00 : 7'($urandom);
            rst         = ($urandom % 150) == 0;
            tick();
`ifdef LFSR_GEN_WRAP_DET_EN
            exp_wrap = m_wrap; exp_per = m_per;
`else
            exp_wrap = 0; exp_per = 0;
`endif
            n_checks++;
            if (bus.o_state !== m_st || bus.o_bit !== m_st[0] ||
                bus.o_valid !== (m_mode == M_RUN) || bus.o_lockup !== (m_mode == M_LOCK) ||
                bus.o_wrap !== exp_wrap || bus.o_period !== 16'(exp_per)) begin
                n_errors++;
                $display("FAIL rand[%0d] st=%h v=%b lk=%b w=%b p=%0d exp st=%h v=%b lk=%b w=%b p=%0d",
                         c, bus.o_state, bus.o_valid, bus.o_lockup, bus.o_wrap, bus.o_period,
                         m_st, m_mode == M_RUN, m_mode == M_LOCK, exp_wrap, exp_per);
            end
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_lockup();
        test_load_handshake();
        test_step7();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
